// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter driving open-drain enables
// Sends one byte as start/8 data/odd parity/stop, then checks the device ACK under a global timeout.
module ps2_host_tx #(
  parameter int CLK_LOW_CYCLES    = 6000,
  parameter int DATA_SETUP_CYCLES = 100,
  parameter int TIMEOUT_CYCLES    = 1000000,
  parameter int FILTER_LEN        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr_ps2,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  localparam int DMAX = (CLK_LOW_CYCLES > DATA_SETUP_CYCLES) ? CLK_LOW_CYCLES : DATA_SETUP_CYCLES;
  localparam int DW   = $clog2(DMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW   = $clog2(FILTER_LEN + 1);

  localparam logic [DW-1:0] RTS_LAST   = DW'(CLK_LOW_CYCLES - 1);
  localparam logic [DW-1:0] SETUP_LAST = DW'(DATA_SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RTS,
    S_START,
    S_SEND,
    S_ACK,
    S_RELEASE
  } state_t;

  // Line conditioning: both lines synchronized, clock additionally debounced.
  logic [1:0]    c_sync_q, d_sync_q;
  logic          c_s, d_s;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_q, fall_d;

  assign c_s = c_sync_q[1];
  assign d_s = d_sync_q[1];

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall_d = 1'b0;
    if (c_s != filt_q) begin
      if (fcnt_q == FILT_LAST) begin
        filt_d = c_s;
        fall_d = ~c_s;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      fall_q   <= 1'b0;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c_in};
      d_sync_q <= {d_sync_q[0], ps2d_in};
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      fall_q   <= fall_d;
    end
  end

  state_t        state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    bits_q, bits_d;
  logic [9:0]    frame_q, frame_d;
  logic          pc_q, pc_d, pd_q, pd_d;
  logic          idle_q, idle_d, done_q, done_d, err_q, err_d;
  logic          in_window;

  assign in_window = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_RELEASE);

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    tmo_d   = tmo_q;
    bits_d  = bits_q;
    frame_d = frame_q;
    pc_d    = pc_q;
    pd_d    = pd_q;
    idle_d  = idle_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (in_window) begin
      tmo_d = tmo_q + TW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (wr_ps2) begin
          state_d = S_RTS;
          frame_d = {1'b1, ~^din, din};
          bits_d  = '0;
          dcnt_d  = '0;
          pc_d    = 1'b1;
          pd_d    = 1'b0;
          idle_d  = 1'b0;
        end
      end
      S_RTS: begin
        if (dcnt_q == RTS_LAST) begin
          state_d = S_START;
          dcnt_d  = '0;
          pd_d    = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_START: begin
        if (dcnt_q == SETUP_LAST) begin
          state_d = S_SEND;
          pc_d    = 1'b0;
          tmo_d   = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_SEND: begin
        if (fall_q) begin
          pd_d    = ~frame_q[0];
          frame_d = {1'b0, frame_q[9:1]};
          bits_d  = bits_q + 4'd1;
          if (bits_q == 4'd9) begin
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (fall_q) begin
          if (!d_s) begin
            state_d = S_RELEASE;
          end else begin
            state_d = S_IDLE;
            idle_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      S_RELEASE: begin
        if (filt_q && d_s) begin
          state_d = S_IDLE;
          idle_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = 1'b0;
        pd_d    = 1'b0;
        idle_d  = 1'b1;
      end
    endcase
    // Timeout wins over any same-cycle clock edge or ACK decision.
    if (in_window && (tmo_q == TMO_LAST)) begin
      state_d = S_IDLE;
      pc_d    = 1'b0;
      pd_d    = 1'b0;
      idle_d  = 1'b1;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      tmo_q   <= '0;
      bits_q  <= '0;
      frame_q <= '0;
      pc_q    <= 1'b0;
      pd_q    <= 1'b0;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      tmo_q   <= tmo_d;
      bits_q  <= bits_d;
      frame_q <= frame_d;
      pc_q    <= pc_d;
      pd_q    <= pd_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ps2c_oe      = pc_q;
  assign ps2d_oe      = pd_q;
  assign tx_idle      = idle_q;
  assign tx_done_tick = done_q;
  assign tx_err_tick  = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a PS/2 device model
// A per-cycle checker tracks request phases; device tasks capture the serialized frame.
module tb_ps2_host_tx;

  localparam int CL   = 20;
  localparam int DS   = 4;
  localparam int TO   = 2000;
  localparam int FL   = 8;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick;

  // Wired-AND open-drain bus between host and device
  assign ps2c_in = ~(ps2c_oe | dev_c_low);
  assign ps2d_in = ~(ps2d_oe | dev_d_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_LOW_CYCLES(CL),
    .DATA_SETUP_CYCLES(DS),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(FL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .wr_ps2(wr_ps2),
    .ps2c_in(ps2c_in),
    .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe),
    .ps2d_oe(ps2d_oe),
    .tx_idle(tx_idle),
    .tx_done_tick(tx_done_tick),
    .tx_err_tick(tx_err_tick)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] model_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d};
  endfunction

  bit busy = 1'b0;
  bit rst_pend = 1'b0;
  int cyc = 0;
  int acc_cyc = 0;
  int ofs = 0;
  int n_done = 0;
  int n_err = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_pend) begin
      busy = 1'b0;
      chk("reset_no_tick", 32'({tx_done_tick, tx_err_tick}), 32'd0);
    end else if (tx_done_tick || tx_err_tick) begin
      chk("tick_only_when_busy", 32'(busy), 32'd1);
      chk("tick_exclusive", 32'(tx_done_tick & tx_err_tick), 32'd0);
      if (tx_done_tick) n_done++;
      if (tx_err_tick) n_err++;
      busy = 1'b0;
    end
    chk("tx_idle", 32'(tx_idle), 32'(!busy));
    if (!busy) begin
      chk("idle_oe", 32'({ps2c_oe, ps2d_oe}), 32'd0);
    end else begin
      ofs = cyc - acc_cyc;
      if (ofs >= 1 && ofs <= CL) chk("rts_oe", 32'({ps2c_oe, ps2d_oe}), 32'b10);
      else if (ofs > CL && ofs <= CL + DS) chk("start_oe", 32'({ps2c_oe, ps2d_oe}), 32'b11);
      else if (ofs == CL + DS + 1) chk("clk_release_oe", 32'({ps2c_oe, ps2d_oe}), 32'b01);
    end
    rst_pend = !reset;
    if (reset && !busy && wr_ps2) begin
      busy = 1'b1;
      acc_cyc = cyc;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic send(input logic [7:0] d);
    din = d;
    wr_ps2 = 1'b1;
    wait_cyc(1);
    wr_ps2 = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (tx_idle !== 1'b1 && n < 3000) begin
      wait_cyc(1);
      n++;
    end
    chk("idle_reached", 32'(tx_idle), 32'd1);
  endtask

  task automatic dev_frame(input int nclk, input bit ack, input bit glitch, output logic [9:0] got);
    int w = 0;
    got = '0;
    while (!(ps2c_oe === 1'b0 && ps2d_oe === 1'b1) && w < 200) begin
      wait_cyc(1);
      w++;
    end
    chk("start_bit_seen", 32'(w < 200), 32'd1);
    if (w >= 200) return;
    wait_cyc(10);
    for (int i = 0; i < nclk; i++) begin
      if (i == 10 && ack) dev_d_low = 1'b1;
      dev_c_low = 1'b1;
      wait_cyc(HALF);
      dev_c_low = 1'b0;
      if (glitch && i == 4) begin
        wait_cyc(5);
        dev_c_low = 1'b1;
        wait_cyc(3);
        dev_c_low = 1'b0;
        wait_cyc(HALF / 2 - 8);
      end else begin
        wait_cyc(HALF / 2);
      end
      if (i < 10) got[i] = ps2d_in;
      wait_cyc(HALF / 2);
    end
    dev_d_low = 1'b0;
  endtask

  logic [9:0] got;
  int d0, e0, k;

  initial begin
    wait_cyc(3);
    chk("reset_oe", 32'({ps2c_oe, ps2d_oe}), 32'd0);
    chk("reset_idle", 32'(tx_idle), 32'd1);
    chk("reset_ticks", 32'({tx_done_tick, tx_err_tick}), 32'd0);
    reset = 1'b1;
    wait_cyc(3);

    // 0xF4 with an ignored 0x00 request in the middle of the frame
    d0 = n_done; e0 = n_err;
    send(8'hF4);
    fork
      dev_frame(11, 1'b1, 1'b0, got);
      begin
        wait_cyc(300);
        din = 8'h00;
        wr_ps2 = 1'b1;
        wait_cyc(1);
        wr_ps2 = 1'b0;
      end
    join
    wait_idle();
    wait_cyc(5);
    chk("f4_bits_literal", 32'(got), 32'h2F4);
    chk("f4_bits_model", 32'(got), 32'(model_frame(8'hF4)));
    chk("f4_done", 32'(n_done - d0), 32'd1);
    chk("f4_err", 32'(n_err - e0), 32'd0);

    // 0xFF needs parity 1
    d0 = n_done; e0 = n_err;
    send(8'hFF);
    dev_frame(11, 1'b1, 1'b0, got);
    wait_idle();
    wait_cyc(5);
    chk("ff_bits_literal", 32'(got), 32'h3FF);
    chk("ff_done", 32'(n_done - d0), 32'd1);
    chk("ff_err", 32'(n_err - e0), 32'd0);

    // Short clock glitch during a high phase must not shift a bit
    d0 = n_done; e0 = n_err;
    send(8'h5A);
    dev_frame(11, 1'b1, 1'b1, got);
    wait_idle();
    wait_cyc(5);
    chk("glitch_bits_literal", 32'(got), 32'h35A);
    chk("glitch_bits_model", 32'(got), 32'(model_frame(8'h5A)));
    chk("glitch_done", 32'(n_done - d0), 32'd1);

    // Device leaves data high on the ACK clock
    d0 = n_done; e0 = n_err;
    send(8'hF4);
    dev_frame(11, 1'b0, 1'b0, got);
    wait_idle();
    wait_cyc(5);
    chk("noack_bits_model", 32'(got), 32'(model_frame(8'hF4)));
    chk("noack_err", 32'(n_err - e0), 32'd1);
    chk("noack_done", 32'(n_done - d0), 32'd0);

    // Device never clocks: error exactly TO cycles after clock release
    d0 = n_done; e0 = n_err;
    send(8'h12);
    k = 0;
    while (ps2c_oe !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_clk_released", 32'(ps2c_oe), 32'd0);
    k = 0;
    while (tx_err_tick !== 1'b1 && k < TO + 500) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_cycles", 32'(k), 32'(TO));
    chk("tmo_oe", 32'({ps2c_oe, ps2d_oe}), 32'd0);
    wait_cyc(5);
    chk("tmo_err", 32'(n_err - e0), 32'd1);
    chk("tmo_done", 32'(n_done - d0), 32'd0);

    // Reset in the middle of SEND
    d0 = n_done; e0 = n_err;
    send(8'hF4);
    dev_frame(3, 1'b0, 1'b0, got);
    reset = 1'b0;
    wait_cyc(1);
    reset = 1'b1;
    chk("midrst_oe", 32'({ps2c_oe, ps2d_oe}), 32'd0);
    chk("midrst_idle", 32'(tx_idle), 32'd1);
    wait_cyc(50);
    chk("midrst_no_done", 32'(n_done - d0), 32'd0);
    chk("midrst_no_err", 32'(n_err - e0), 32'd0);

    // Clean frame after reset
    d0 = n_done; e0 = n_err;
    send(8'h00);
    dev_frame(11, 1'b1, 1'b0, got);
    wait_idle();
    wait_cyc(5);
    chk("zero_bits_literal", 32'(got), 32'h300);
    chk("zero_done", 32'(n_done - d0), 32'd1);
    chk("zero_err", 32'(n_err - e0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. Serializes one command byte to the mouse (e.g. 0xF4 enable reporting, 0xFF reset) over the shared open-drain ps2c/ps2d lines, and reports device ACK or failure. Sits beside mouseController in the 50 MHz clock domain. tx_idle gates the receiver so it ignores the host frame. The top level converts the two drive enables into open-drain pulls (enable=1 drives 0, otherwise high-Z).

## Interface
Parameters:
- CLK_LOW_CYCLES, 6000, request-to-send clock-low hold (120 µs @ 50 MHz)
- DATA_SETUP_CYCLES, 100, data held low before clock release (2 µs)
- TIMEOUT_CYCLES, 1000000, limit from clock release to ACK completion (20 ms)
- FILTER_LEN, 8, consecutive agreeing samples needed to change the filtered ps2c

Ports:
- clk  in  1  50 MHz system clock (clk_50MHz at top level)
- reset  in  1  synchronous, active-low reset
- din  in  8  command byte, sampled with wr_ps2
- wr_ps2  in  1  one-cycle start strobe; ignored unless tx_idle=1
- ps2c_in  in  1  raw ps2c line level
- ps2d_in  in  1  raw ps2d line level
- ps2c_oe  out  1  1 = pull ps2c low
- ps2d_oe  out  1  1 = pull ps2d low
- tx_idle  out  1  1 = no frame in progress
- tx_done_tick  out  1  one-cycle pulse: frame ACKed and bus returned high
- tx_err_tick  out  1  one-cycle pulse: timeout or missing ACK

## Operation
- Input conditioning:
  - ps2c_in and ps2d_in each pass through a 2-FF synchronizer.
  - Synchronized ps2c feeds a filter: the filtered value changes only after FILTER_LEN consecutive equal samples.
  - fall_tick = filtered ps2c going 1→0.
- Frame register, loaded on accepted wr_ps2: {stop=1, parity=~^din, din}, 10 bits, shifted LSB first. Parity is odd.
- States:
  - IDLE
    - Outputs: both oe=0, tx_idle=1.
    - wr_ps2 → RTS; load frame; bit counter=0.
  - RTS
    - ps2c_oe=1.
    - After CLK_LOW_CYCLES → START.
  - START
    - ps2c_oe=1 and ps2d_oe=1 (start bit).
    - After DATA_SETUP_CYCLES → SEND: ps2c_oe=0, timeout counter cleared.
  - SEND
    - Each fall_tick: ps2d_oe ← ~frame[0], shift, counter+1.
    - Counter reaching 10 (stop bit released, ps2d_oe=0) → ACK.
  - ACK
    - Next fall_tick: sample synchronized ps2d.
    - 0 → RELEASE.
    - 1 → tx_err_tick, go to IDLE.
  - RELEASE
    - Wait until filtered ps2c=1 and synchronized ps2d=1.
    - Then tx_done_tick → IDLE.
- Timeout:
  - Counts in SEND, ACK and RELEASE.
  - Reaching TIMEOUT_CYCLES → tx_err_tick; both oe=0; → IDLE.
  - Timeout has priority over a same-cycle fall_tick.
- wr_ps2 while tx_idle=0 has no effect: no queueing, din not resampled.
- Reset mid-frame: next edge gives both oe=0 and IDLE; no tick is emitted. Partial frames are never resumed.
- Exactly one of tx_done_tick/tx_err_tick fires per accepted request, except when reset intervenes.

## Timing
- Reset values: ps2c_oe=0, ps2d_oe=0, tx_idle=1, tx_done_tick=0, tx_err_tick=0; filter state=1.
- All outputs are registered.
- wr_ps2 high at edge N:
  - Edge N+1: ps2c_oe=1, tx_idle=0.
  - Edge N+1+CLK_LOW_CYCLES: ps2d_oe=1.
  - After a further DATA_SETUP_CYCLES: ps2c_oe=0.
- Data updates: ps2d_oe changes on the edge after fall_tick.
- Input-to-fall_tick latency: 2 sync stages + FILTER_LEN cycles, well inside the 30–50 µs PS/2 low phase.
- Ticks are exactly one clk cycle wide. tx_idle rises in the same cycle as the tick.
- Minimum gap between accepted frames: 1 cycle (an IDLE cycle).

## Test plan
Benches use CLK_LOW_CYCLES=20, DATA_SETUP_CYCLES=4, TIMEOUT_CYCLES=2000, FILTER_LEN=8. Device model clocks at 40-cycle half-period.

- din=0xF4:
  - ps2c_oe low-hold of 20 cycles, then start bit.
  - Bits on ps2d after successive falls: 0,0,1,0,1,1,1,1, parity 0, stop released.
  - Model ACKs → one tx_done_tick; tx_idle=1; both oe=0.
- din=0xFF: parity bit 1; the ACK path completes with tx_done_tick.
- Device never clocks after release → tx_err_tick exactly 2000 cycles after ps2c_oe falls; both oe=0; no tx_done_tick.
- Model leaves ps2d high on the 11th falling edge → tx_err_tick; no tx_done_tick.
- wr_ps2 with din=0x00 pulsed mid-frame of a 0xF4 send → frame bits unchanged, single completion.
- reset low mid-SEND → next edge both oe=0, tx_idle=1, no ticks.
- 3-cycle low glitch on ps2c_in during SEND → no bit shift and no fall_tick.
